alu_arbiter_seq: RTL

ALU_ARBITER_SEQ -- requirements
Module: alu_arbiter_seq

---
 rtl/alu_arbiter_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter_seq.sv
// Two-requester round-robin front end for a shared, fixed-latency ALU datapath.
// Runs one command at a time and returns the result through a valid/ready response port.
module alu_arbiter_seq #(
    parameter int N   = 2,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic         req0_opcode,
    input  logic         req1_opcode,
    input  logic         req0_sig,
    input  logic         req1_sig,
    input  logic         req0_mode,
    input  logic         req1_mode,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         alu_opcode,
    output logic         alu_sig,
    output logic         alu_mode,
    input  logic [N-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_id,
    output logic         busy
);

    localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t        state;
    logic          ptr;
    logic          cmd_id;
    logic [CW-1:0] cnt;
    logic          grant0;
    logic          grant1;

    // Grants are only offered in IDLE and never while reset is held; ptr breaks ties.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (req0_valid && (!req1_valid || !ptr))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            cmd_id     <= 1'b0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= 1'b0;
            alu_sig    <= 1'b0;
            alu_mode   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0) begin
                        alu_a      <= req0_a;
                        alu_b      <= req0_b;
                        alu_opcode <= req0_opcode;
                        alu_sig    <= req0_sig;
                        alu_mode   <= req0_mode;
                        cmd_id     <= 1'b0;
                        cnt        <= CW'(LAT);
                        state      <= EXEC;
                    end else if (grant1) begin
                        alu_a      <= req1_a;
                        alu_b      <= req1_b;
                        alu_opcode <= req1_opcode;
                        alu_sig    <= req1_sig;
                        alu_mode   <= req1_mode;
                        cmd_id     <= 1'b1;
                        cnt        <= CW'(LAT);
                        state      <= EXEC;
                    end
                end
                // The extra cycle beyond LAT lets the datapath output register settle before capture.
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_data  <= alu_result;
                        rsp_id    <= cmd_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= ~rsp_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
